pipe_ctrl: RTL and testbench

- Parametrised pipeline sequencer for the in-order RISC-V core: owns per-stage valid bits and per-stage register load enables.
- Adds what the current fixed pipeline lacks: RAW/WAW scoreboard stall, multi-cycle EX hold (divider), and branch/jump flush.
- Sits beside the stage registers in the core top. The stage registers load data only when the matching stage_en_o bit is high.

---
 rtl/pipe_ctrl_pkg.sv | 22 ++
 rtl/pipe_scoreboard.sv | 48 ++++
 rtl/pipe_ctrl.sv | 168 ++++++++++++++++
 tb/tb_pipe_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared constants and helpers for the pipeline sequencer.
// Stage indices, default widths and a saturating counter increment.
package pipe_ctrl_pkg;

  // Fixed stage positions; stages above STG_EX only advance.
  localparam int STG_IFID = 0;
  localparam int STG_IDEX = 1;
  localparam int STG_EX   = 2;

  localparam int DEF_NUM_STAGES = 4;
  localparam int DEF_REG_ADDR_W = 5;

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v,
    input logic        inc
  );
    return (inc && (v != CNT_MAX)) ? v + 32'd1 : v;
  endfunction

endpackage

// File: rtl/pipe_scoreboard.sv
// pipe_scoreboard: one pending-write bit per architectural register.
// Ports: clk, rst, set_en/set_addr, clr_en/clr_addr, rs1/rs2/rd lookup
// addresses with matching *_hit outputs, sb = full registered vector.
module pipe_scoreboard
  import pipe_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_REG_ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 set_en,
  input  logic [ADDR_W-1:0]    set_addr,
  input  logic                 clr_en,
  input  logic [ADDR_W-1:0]    clr_addr,
  input  logic [ADDR_W-1:0]    rs1,
  input  logic [ADDR_W-1:0]    rs2,
  input  logic [ADDR_W-1:0]    rd,
  output logic                 rs1_hit,
  output logic                 rs2_hit,
  output logic                 rd_hit,
  output logic [2**ADDR_W-1:0] sb
);

  localparam int NREG = 2**ADDR_W;

  logic [NREG-1:0] sb_q;
  logic [NREG-1:0] sb_n;

  // x0 never has a pending write.
  always_comb begin
    sb_n = sb_q;
    if (clr_en) sb_n[clr_addr] = 1'b0;
    if (set_en) sb_n[set_addr] = 1'b1;
    sb_n[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sb_q <= '0;
    else     sb_q <= sb_n;
  end

  // Lookups read the registered vector: no same-cycle bypass.
  assign rs1_hit = sb_q[rs1];
  assign rs2_hit = sb_q[rs2];
  assign rd_hit  = sb_q[rd];
  assign sb      = sb_q;

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: per-stage valid bits and register load enables with RAW/WAW
// scoreboard stall, multi-cycle EX hold and branch flush.
// Ports: clk, rst (async, high); if_vld_i/if_ready_o fetch handshake;
// id_rs1/rs2/rd + enables of the stage-0 instruction; ex_busy_i, flush_i;
// stage_vld_o, stage_en_o, hazard_o, sb_o; stall_cnt_o, flush_cnt_o are
// live only when PIPE_CTRL_PERF_EN is defined, otherwise tied to zero.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NUM_STAGES = DEF_NUM_STAGES,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     if_vld_i,
  output logic                     if_ready_o,
  input  logic [REG_ADDR_W-1:0]    id_rs1_i,
  input  logic                     id_rs1_en_i,
  input  logic [REG_ADDR_W-1:0]    id_rs2_i,
  input  logic                     id_rs2_en_i,
  input  logic [REG_ADDR_W-1:0]    id_rd_i,
  input  logic                     id_rd_wr_en_i,
  input  logic                     ex_busy_i,
  input  logic                     flush_i,
  output logic [NUM_STAGES-1:0]    stage_vld_o,
  output logic [NUM_STAGES-1:0]    stage_en_o,
  output logic                     hazard_o,
  output logic [2**REG_ADDR_W-1:0] sb_o,
  output logic [31:0]              stall_cnt_o,
  output logic [31:0]              flush_cnt_o
);

  localparam int LAST = NUM_STAGES - 1;

  logic [NUM_STAGES-1:0] vld_q;
  logic [NUM_STAGES-1:0] vld_n;
  logic [NUM_STAGES-1:0] en;

  // Destination tracking for stages 1..LAST; stage 0 uses id_* directly.
  logic [REG_ADDR_W-1:0] rd_q [1:LAST];
  logic [REG_ADDR_W-1:0] rd_n [1:LAST];
  logic [LAST:1]         wr_q;
  logic [LAST:1]         wr_n;

  logic rs1_hit;
  logic rs2_hit;
  logic rd_hit;
  logic raw;
  logic waw;
  logic hold_ex;
  logic hold0;
  logic sb_set;
  logic sb_clr;

  assign raw = vld_q[STG_IFID]
             & ((id_rs1_en_i & (id_rs1_i != '0) & rs1_hit)
              | (id_rs2_en_i & (id_rs2_i != '0) & rs2_hit));

  assign waw = vld_q[STG_IFID] & id_rd_wr_en_i
             & (id_rd_i != '0) & rd_hit;

  assign hazard_o = raw | waw;
  assign hold_ex  = ex_busy_i & vld_q[STG_IDEX];
  assign hold0    = (hold_ex | hazard_o) & ~flush_i;

  assign if_ready_o  = ~hold0;
  assign stage_vld_o = vld_q;
  assign stage_en_o  = en;

  // Set on the 0->1 transfer, clear as the oldest writer retires.
  assign sb_set = vld_q[STG_IFID] & id_rd_wr_en_i & (id_rd_i != '0)
                & ~hold_ex & ~hazard_o & ~flush_i;
  assign sb_clr = vld_q[LAST] & wr_q[LAST];

  always_comb begin
    vld_n = vld_q;
    rd_n  = rd_q;
    wr_n  = wr_q;
    en    = '1;

    if (flush_i) begin
      vld_n[STG_IFID] = 1'b0;
    end else if (hold0) begin
      en[STG_IFID] = 1'b0;
    end else begin
      vld_n[STG_IFID] = if_vld_i;
    end

    // Flush and hazard both inject a bubble unless EX is holding.
    if (hold_ex) begin
      en[STG_IDEX] = 1'b0;
    end else if (hazard_o | flush_i) begin
      vld_n[STG_IDEX] = 1'b0;
      wr_n[STG_IDEX]  = 1'b0;
    end else begin
      vld_n[STG_IDEX] = vld_q[STG_IFID];
      rd_n[STG_IDEX]  = id_rd_i;
      wr_n[STG_IDEX]  = id_rd_wr_en_i;
    end

    if (hold_ex) begin
      vld_n[STG_EX] = 1'b0;
      wr_n[STG_EX]  = 1'b0;
    end else begin
      vld_n[STG_EX] = vld_q[STG_IDEX];
      rd_n[STG_EX]  = rd_q[STG_IDEX];
      wr_n[STG_EX]  = wr_q[STG_IDEX];
    end

    for (int s = STG_EX + 1; s < NUM_STAGES; s++) begin
      vld_n[s] = vld_q[s-1];
      rd_n[s]  = rd_q[s-1];
      wr_n[s]  = wr_q[s-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      wr_q  <= '0;
      rd_q  <= '{default: '0};
    end else begin
      vld_q <= vld_n;
      wr_q  <= wr_n;
      rd_q  <= rd_n;
    end
  end

  pipe_scoreboard #(
    .ADDR_W (REG_ADDR_W)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_en   (sb_set),
    .set_addr (id_rd_i),
    .clr_en   (sb_clr),
    .clr_addr (rd_q[LAST]),
    .rs1      (id_rs1_i),
    .rs2      (id_rs2_i),
    .rd       (id_rd_i),
    .rs1_hit  (rs1_hit),
    .rs2_hit  (rs2_hit),
    .rd_hit   (rd_hit),
    .sb       (sb_o)
  );

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_q;
  logic [31:0] flush_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= sat_inc(stall_q, hold0);
      flush_q <= sat_inc(flush_q, flush_i);
    end
  end

  assign stall_cnt_o = stall_q;
  assign flush_cnt_o = flush_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed pipeline scenarios with a retire scoreboard.
// Accepted instructions are queued; each stage-3 retirement pops one.
module tb_pipe_ctrl;

`ifdef PIPE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct packed {
    logic [4:0] rs1;
    logic       r1;
    logic [4:0] rs2;
    logic       r2;
    logic [4:0] rd;
    logic       wr;
  } ins_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_vld_i = 1'b0;
  logic        if_ready_o;
  logic [4:0]  id_rs1_i = '0;
  logic        id_rs1_en_i = 1'b0;
  logic [4:0]  id_rs2_i = '0;
  logic        id_rs2_en_i = 1'b0;
  logic [4:0]  id_rd_i = '0;
  logic        id_rd_wr_en_i = 1'b0;
  logic        ex_busy_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [3:0]  stage_vld_o;
  logic [3:0]  stage_en_o;
  logic        hazard_o;
  logic [31:0] sb_o;
  logic [31:0] stall_cnt_o;
  logic [31:0] flush_cnt_o;

  int total = 0;
  int bad   = 0;
  int nret  = 0;

  ins_t prog[$];
  ins_t exp_q[$];
  ins_t s0;
  ins_t ret_e;
  bit   s0_v = 1'b0;

  pipe_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .if_vld_i      (if_vld_i),
    .if_ready_o    (if_ready_o),
    .id_rs1_i      (id_rs1_i),
    .id_rs1_en_i   (id_rs1_en_i),
    .id_rs2_i      (id_rs2_i),
    .id_rs2_en_i   (id_rs2_en_i),
    .id_rd_i       (id_rd_i),
    .id_rd_wr_en_i (id_rd_wr_en_i),
    .ex_busy_i     (ex_busy_i),
    .flush_i       (flush_i),
    .stage_vld_o   (stage_vld_o),
    .stage_en_o    (stage_en_o),
    .hazard_o      (hazard_o),
    .sb_o          (sb_o),
    .stall_cnt_o   (stall_cnt_o),
    .flush_cnt_o   (flush_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic ins_t mk(
    input logic [4:0] rs1, input logic r1,
    input logic [4:0] rs2, input logic r2,
    input logic [4:0] rd,  input logic wr
  );
    ins_t t;
    t.rs1 = rs1; t.r1 = r1;
    t.rs2 = rs2; t.r2 = r2;
    t.rd  = rd;  t.wr = wr;
    return t;
  endfunction

  task automatic drive();
    if_vld_i      = (prog.size() != 0);
    id_rs1_i      = s0_v ? s0.rs1 : 5'd0;
    id_rs1_en_i   = s0_v ? s0.r1  : 1'b0;
    id_rs2_i      = s0_v ? s0.rs2 : 5'd0;
    id_rs2_en_i   = s0_v ? s0.r2  : 1'b0;
    id_rd_i       = s0_v ? s0.rd  : 5'd0;
    id_rd_wr_en_i = s0_v ? s0.wr  : 1'b0;
  endtask

  // One clock: stage-0 occupancy follows the fetch handshake.
  task automatic tick();
    logic adv, fl, fv;
    adv = if_ready_o;
    fl  = flush_i;
    fv  = if_vld_i;
    @(posedge clk);
    #1;
    if (fl) begin
      if (s0_v) void'(exp_q.pop_back());
      s0_v = 1'b0;
    end else if (adv) begin
      s0_v = fv;
      if (fv) begin
        s0 = prog.pop_front();
        exp_q.push_back(s0);
      end
    end
    flush_i = 1'b0;
    drive();
    #1;
  endtask

  task automatic row(string tag, logic [3:0] v, logic h, logic r);
    tick();
    chk({tag, "_vld"}, 32'(stage_vld_o), 32'(v));
    chk({tag, "_haz"}, 32'(hazard_o), 32'(h));
    chk({tag, "_rdy"}, 32'(if_ready_o), 32'(r));
  endtask

  always @(negedge clk) begin
    if (!rst && stage_vld_o[3]) begin
      chk("ret_q", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        ret_e = exp_q.pop_front();
        nret++;
        if (ret_e.wr && ret_e.rd != 5'd0)
          chk("ret_sb", 32'(sb_o[ret_e.rd]), 32'd1);
        else
          chk("ret_x0", 32'(sb_o[0]), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    #12;
    chk("rst_vld", 32'(stage_vld_o), 32'd0);
    chk("rst_sb", sb_o, 32'd0);
    chk("rst_stall", stall_cnt_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive();
    #1;

    // RAW on x5
    prog.push_back(mk(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1));
    prog.push_back(mk(5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1));
    drive(); #1;
    row("raw1", 4'b0001, 1'b0, 1'b1);
    row("raw2", 4'b0011, 1'b1, 1'b0);
    chk("raw2_en", 32'(stage_en_o), 32'b1110);
    chk("raw2_sb5", 32'(sb_o[5]), 32'd1);
    row("raw3", 4'b0101, 1'b1, 1'b0);
    row("raw4", 4'b1001, 1'b1, 1'b0);
    chk("raw4_sb5", 32'(sb_o[5]), 32'd1);
    row("raw5", 4'b0001, 1'b0, 1'b1);
    chk("raw5_sb5", 32'(sb_o[5]), 32'd0);
    chk("raw5_en", 32'(stage_en_o), 32'b1111);
    row("raw6", 4'b0010, 1'b0, 1'b1);
    chk("raw6_sb6", 32'(sb_o[6]), 32'd1);
    repeat (3) tick();
    chk("raw_drain", 32'(stage_vld_o), 32'd0);

    // x0 writer then x0 reader
    prog.push_back(mk(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1));
    prog.push_back(mk(5'd0, 1'b1, 5'd0, 1'b1, 5'd9, 1'b0));
    drive(); #1;
    row("x0a", 4'b0001, 1'b0, 1'b1);
    row("x0b", 4'b0011, 1'b0, 1'b1);
    chk("x0b_sb", sb_o, 32'd0);
    row("x0c", 4'b0110, 1'b0, 1'b1);
    chk("x0c_sb", sb_o, 32'd0);
    repeat (3) tick();

    // divider hold, 5 busy cycles
    for (int k = 1; k <= 4; k++)
      prog.push_back(mk(5'd0, 1'b0, 5'd0, 1'b0, 5'(k), 1'b1));
    drive(); #1;
    row("d1", 4'b0001, 1'b0, 1'b1);
    row("d2", 4'b0011, 1'b0, 1'b1);
    row("d3", 4'b0111, 1'b0, 1'b1);
    ex_busy_i = 1'b1;
    #1;
    chk("d3_rdy", 32'(if_ready_o), 32'd0);
    row("d4", 4'b1011, 1'b0, 1'b0);
    chk("d4_en", 32'(stage_en_o), 32'b1100);
    for (int k = 5; k <= 8; k++)
      row($sformatf("d%0d", k), 4'b0011, 1'b0, 1'b0);
    ex_busy_i = 1'b0;
    #1;
    row("d9", 4'b0111, 1'b0, 1'b1);
    row("d10", 4'b1110, 1'b0, 1'b1);
    repeat (3) tick();
    chk("d_drain", 32'(stage_vld_o), 32'd0);

    // flush with stage 0 valid and fetch offering
    prog.push_back(mk(5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1));
    prog.push_back(mk(5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1));
    prog.push_back(mk(5'd0, 1'b0, 5'd0, 1'b0, 5'd13, 1'b1));
    drive(); #1;
    row("f1", 4'b0001, 1'b0, 1'b1);
    row("f2", 4'b0011, 1'b0, 1'b1);
    flush_i = 1'b1;
    #1;
    row("f3", 4'b0100, 1'b0, 1'b1);
    chk("f3_cnt", flush_cnt_o, PERF ? 32'd1 : 32'd0);
    chk("f3_sb12", 32'(sb_o[12]), 32'd0);
    row("f4", 4'b1001, 1'b0, 1'b1);
    row("f5", 4'b0010, 1'b0, 1'b1);
    repeat (3) tick();
    chk("f_drain", 32'(stage_vld_o), 32'd0);

    // WAW on x7
    prog.push_back(mk(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1));
    prog.push_back(mk(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1));
    drive(); #1;
    row("w1", 4'b0001, 1'b0, 1'b1);
    row("w2", 4'b0011, 1'b1, 1'b0);
    chk("w2_sb7", 32'(sb_o[7]), 32'd1);
    row("w3", 4'b0101, 1'b1, 1'b0);
    chk("w3_sb7", 32'(sb_o[7]), 32'd1);
    row("w4", 4'b1001, 1'b1, 1'b0);
    chk("w4_sb7", 32'(sb_o[7]), 32'd1);
    row("w5", 4'b0001, 1'b0, 1'b1);
    chk("w5_sb7", 32'(sb_o[7]), 32'd0);
    row("w6", 4'b0010, 1'b0, 1'b1);
    chk("w6_sb7", 32'(sb_o[7]), 32'd1);
    row("w7", 4'b0100, 1'b0, 1'b1);
    row("w8", 4'b1000, 1'b0, 1'b1);
    chk("w8_sb7", 32'(sb_o[7]), 32'd1);
    row("w9", 4'b0000, 1'b0, 1'b1);
    chk("w9_sb7", 32'(sb_o[7]), 32'd0);

    chk("q_empty", 32'(exp_q.size()), 32'd0);
    chk("nret", 32'(nret), 32'd12);
    chk("stall_cnt", stall_cnt_o, PERF ? 32'd11 : 32'd0);
    chk("flush_cnt", flush_cnt_o, PERF ? 32'd1 : 32'd0);

    // async reset with all four stages valid
    for (int k = 20; k <= 24; k++)
      prog.push_back(mk(5'd0, 1'b0, 5'd0, 1'b0, 5'(k), 1'b1));
    drive(); #1;
    row("m1", 4'b0001, 1'b0, 1'b1);
    row("m2", 4'b0011, 1'b0, 1'b1);
    row("m3", 4'b0111, 1'b0, 1'b1);
    row("m4", 4'b1111, 1'b0, 1'b1);
    chk("m4_sb", sb_o, 32'h0070_0000);
    rst = 1'b1;
    #1;
    chk("mrst_vld", 32'(stage_vld_o), 32'd0);
    chk("mrst_sb", sb_o, 32'd0);
    chk("mrst_stall", stall_cnt_o, 32'd0);
    prog.delete();
    exp_q.delete();
    s0_v = 1'b0;
    drive();
    @(negedge clk);
    rst = 1'b0;
    #1;

    // pipeline resumes after reset
    prog.push_back(mk(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1));
    drive(); #1;
    row("s1", 4'b0001, 1'b0, 1'b1);
    row("s2", 4'b0010, 1'b0, 1'b1);
    row("s3", 4'b0100, 1'b0, 1'b1);
    row("s4", 4'b1000, 1'b0, 1'b1);
    row("s5", 4'b0000, 1'b0, 1'b1);
    chk("s5_sb", sb_o, 32'd0);
    chk("nret_end", 32'(nret), 32'd13);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
